// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine for port A of the 320x240 RGB332 framebuffer.
// The optional fb_gnt arbitration input is enabled by defining FB_RECT_FILL_GRANT_EN.
module fb_rect_fill #(
  parameter int FB_W    = 320,
  parameter int FB_H    = 240,
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 8
) (
  input  logic               aclk,
  input  logic               arstn,
`ifdef FB_RECT_FILL_GRANT_EN
  input  logic               fb_gnt,
`endif
  input  logic               start,
  input  logic [8:0]         x0,
  input  logic [7:0]         y0,
  input  logic [9:0]         w,
  input  logic [8:0]         h,
  input  logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done,
  output logic               fb_wea,
  output logic [ADDR_W-1:0]  fb_addra,
  output logic [COLOR_W-1:0] fb_dina
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  localparam logic [10:0]       XLIM     = 11'(FB_W);
  localparam logic [10:0]       YLIM     = 11'(FB_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

  state_t state, state_next;

  // Command fields captured in IDLE
  logic [8:0]         x0_q;
  logic [7:0]         y0_q;
  logic [9:0]         w_q;
  logic [8:0]         h_q;
  logic [COLOR_W-1:0] color_q;

  // Raster walk state
  logic [8:0]         x_cnt, x_last;
  logic [7:0]         y_cnt, y_last;
  logic [ADDR_W-1:0]  row_base, cur_addr;

  logic [10:0]        x_sum, y_sum, xe, ye;
  logic [ADDR_W-1:0]  base;
  logic               empty, accept, advance, at_row_end, at_last;

`ifdef FB_RECT_FILL_GRANT_EN
  assign advance = fb_gnt;
`else
  assign advance = 1'b1;
`endif

  // A start that lands while done is still showing belongs to the finished
  // command's DONE phase and is dropped rather than launching a new fill.
  assign accept = (state == IDLE) && start && !done;

  // Clip: 11-bit sums cannot wrap for any 9/10-bit operand combination.
  assign x_sum = {2'b00, x0_q} + {1'b0, w_q};
  assign y_sum = {3'b000, y0_q} + {2'b00, h_q};
  assign xe    = (x_sum > XLIM) ? XLIM : x_sum;
  assign ye    = (y_sum > YLIM) ? YLIM : y_sum;
  assign empty = (w_q == '0) || (h_q == '0) ||
                 ({2'b00, x0_q} >= XLIM) || ({3'b000, y0_q} >= YLIM);

  // y*320 + x as y*256 + y*64 + x; tied to the 320-pixel row pitch.
  assign base = ADDR_W'({y0_q, 8'b0}) + ADDR_W'({y0_q, 6'b0}) + ADDR_W'(x0_q);

  assign at_row_end = (x_cnt == x_last);
  assign at_last    = at_row_end && (y_cnt == y_last);

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: next-state defaults to the current state before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = empty ? DONE : FILL;
      FILL:    if (advance && at_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every register here is a flop, so all updates use non-blocking assignments; all are reset so an abandoned fill leaves nothing behind.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      fb_wea   <= 1'b0;
      fb_addra <= '0;
      fb_dina  <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      x_last   <= '0;
      y_last   <= '0;
      row_base <= '0;
      cur_addr <= '0;
    end else begin
      busy   <= (state == SETUP) || (state == FILL);
      done   <= (state == DONE);
      fb_wea <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            x0_q    <= x0;
            y0_q    <= y0;
            w_q     <= w;
            h_q     <= h;
            color_q <= color;
          end
        end
        SETUP: begin
          x_cnt    <= x0_q;
          y_cnt    <= y0_q;
          x_last   <= 9'(xe - 11'd1);
          y_last   <= 8'(ye - 11'd1);
          row_base <= base;
          cur_addr <= base;
        end
        FILL: begin
          if (advance) begin
            fb_wea   <= 1'b1;
            fb_addra <= cur_addr;
            fb_dina  <= color_q;
            if (at_row_end) begin
              x_cnt    <= x0_q;
              y_cnt    <= y_cnt + 8'd1;
              row_base <= row_base + ROW_STEP;
              cur_addr <= row_base + ROW_STEP;
            end else begin
              x_cnt    <= x_cnt + 9'd1;
              cur_addr <= cur_addr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: each command is checked against a raster model
// of the hand-clipped window plus hand-computed counts, addresses and cycle numbers.
module tb_fb_rect_fill;

  localparam int FB_W = 320;

  logic        aclk = 1'b0;
  logic        arstn = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  x0 = '0;
  logic [7:0]  y0 = '0;
  logic [9:0]  w = '0;
  logic [8:0]  h = '0;
  logic [7:0]  color = '0;
  logic        busy, done, fb_wea;
  logic [16:0] fb_addra;
  logic [7:0]  fb_dina;
`ifdef FB_RECT_FILL_GRANT_EN
  logic        fb_gnt = 1'b1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  fb_rect_fill dut (
    .aclk     (aclk),
    .arstn    (arstn),
`ifdef FB_RECT_FILL_GRANT_EN
    .fb_gnt   (fb_gnt),
`endif
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .color    (color),
    .busy     (busy),
    .done     (done),
    .fb_wea   (fb_wea),
    .fb_addra (fb_addra),
    .fb_dina  (fb_dina)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one command and follow it cycle by cycle; sample c is taken at the
  // falling edge after the c-th rising edge following the start-sampling edge.
  task automatic run_cmd(
    input string      tag,
    input logic [8:0] cx0, input logic [7:0] cy0,
    input logic [9:0] cw,  input logic [8:0] ch, input logic [7:0] cc,
    input int xs, input int xe, input int ys,
    input int exp_n, input int exp_first, input int exp_last,
    input int mid_pulse_at, input bit pulse_done,
    input int abort_at, input int stall_at, input int stall_len);
    int c, n, first_a, last_a, first_c, last_c, done_c, done_cnt, busy_cnt;
    int addr_err, data_err, max_a, mx, my, limit, extra_wr, extra_busy;
    n = 0; first_a = -1; last_a = -1; first_c = -1; last_c = -1; done_c = -1;
    done_cnt = 0; busy_cnt = 0; addr_err = 0; data_err = 0; max_a = 0;
    mx = xs; my = ys; extra_wr = 0; extra_busy = 0;
    limit = exp_n + stall_len + 20;

    @(negedge aclk);
    x0 = cx0; y0 = cy0; w = cw; h = ch; color = cc; start = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    start = 1'b0;
    for (c = 0; c < limit; c++) begin
      if (c > 0) begin
        @(posedge aclk);
        @(negedge aclk);
      end
      if (busy) busy_cnt++;
      if (fb_wea) begin
        if (n == 0) begin first_c = c; first_a = int'(fb_addra); end
        last_c = c;
        last_a = int'(fb_addra);
        if (last_a > max_a) max_a = last_a;
        if (last_a != my * FB_W + mx) addr_err++;
        if (fb_dina !== cc) data_err++;
        n++;
        mx++;
        if (mx == xe) begin mx = xs; my++; end
      end
      if (done) begin done_cnt++; done_c = c; end
      if (abort_at >= 0 && n == abort_at) begin
        arstn = 1'b0;
        #1;
        check({tag, "_rst_outputs"}, 32'({busy, done, fb_wea, fb_addra, fb_dina}), 0);
        check({tag, "_writes_before_rst"}, n, abort_at);
        @(negedge aclk);
        @(negedge aclk);
        arstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(posedge aclk);
          @(negedge aclk);
          if (fb_wea || busy || done) extra_wr++;
        end
        check({tag, "_quiet_after_rst"}, extra_wr, 0);
        return;
      end
      if (done_cnt > 0) break;
      start = (c == mid_pulse_at);
`ifdef FB_RECT_FILL_GRANT_EN
      fb_gnt = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
`endif
    end
    start = pulse_done;
`ifdef FB_RECT_FILL_GRANT_EN
    fb_gnt = 1'b1;
`endif
    for (int k = 0; k < 4; k++) begin
      @(posedge aclk);
      @(negedge aclk);
      start = 1'b0;
      if (fb_wea) extra_wr++;
      if (busy) extra_busy++;
      if (done) done_cnt++;
    end

    check({tag, "_writes"}, n, exp_n);
    check({tag, "_done_cyc"}, done_c, exp_n + stall_len + 2);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_cyc"}, busy_cnt, exp_n + stall_len + 1);
    check({tag, "_post_writes"}, extra_wr, 0);
    check({tag, "_post_busy"}, extra_busy, 0);
    if (exp_n > 0) begin
      check({tag, "_first_addr"}, first_a, exp_first);
      check({tag, "_last_addr"}, last_a, exp_last);
      check({tag, "_first_cyc"}, first_c, 2);
      check({tag, "_span"}, last_c - first_c + 1, exp_n + stall_len);
      check({tag, "_addr_seq_err"}, addr_err, 0);
      check({tag, "_data_err"}, data_err, 0);
      check({tag, "_addr_in_range"}, 32'(max_a <= 76799), 1);
    end
  endtask

  initial begin
    #12;
    check("reset_outputs", 32'({busy, done, fb_wea, fb_addra, fb_dina}), 0);
    @(negedge aclk);
    arstn = 1'b1;

    // Full-screen clear
    run_cmd("clear", 9'd0, 8'd0, 10'd320, 9'd240, 8'h02, 0, 320, 0,
            76800, 0, 76799, -1, 1'b0, -1, 0, 0);
    // Interior rectangle: row ends jump +271
    run_cmd("rect", 9'd10, 8'd10, 10'd50, 9'd30, 8'hE0, 10, 60, 10,
            1500, 3210, 12539, -1, 1'b0, -1, 0, 0);
    // Clipped at the bottom-right corner
    run_cmd("clip", 9'd300, 8'd230, 10'd50, 9'd30, 8'h1C, 300, 320, 230,
            200, 73900, 76799, -1, 1'b0, -1, 0, 0);
    // Empty commands
    run_cmd("empty_w0", 9'd5, 8'd5, 10'd0, 9'd10, 8'h33, 0, 0, 0,
            0, 0, 0, -1, 1'b0, -1, 0, 0);
    run_cmd("empty_x320", 9'd320, 8'd0, 10'd10, 9'd10, 8'h33, 0, 0, 0,
            0, 0, 0, -1, 1'b0, -1, 0, 0);
    run_cmd("empty_h0", 9'd7, 8'd7, 10'd3, 9'd0, 8'h33, 0, 0, 0,
            0, 0, 0, -1, 1'b0, -1, 0, 0);
    run_cmd("empty_y240", 9'd0, 8'd240, 10'd5, 9'd5, 8'h33, 0, 0, 0,
            0, 0, 0, -1, 1'b0, -1, 0, 0);
    // Single last pixel, and maximal w/h clipped without wrap
    run_cmd("pixel", 9'd319, 8'd239, 10'd1, 9'd1, 8'hFF, 319, 320, 239,
            1, 76799, 76799, -1, 1'b0, -1, 0, 0);
    run_cmd("wide", 9'd310, 8'd235, 10'd1023, 9'd511, 8'hA5, 310, 320, 235,
            50, 75510, 76799, -1, 1'b0, -1, 0, 0);
    // start pulsed mid-fill and while done shows; then during the last write
    run_cmd("ign_mid", 9'd5, 8'd2, 10'd4, 9'd3, 8'h55, 5, 9, 2,
            12, 645, 1288, 6, 1'b1, -1, 0, 0);
    run_cmd("ign_last", 9'd5, 8'd2, 10'd4, 9'd3, 8'h66, 5, 9, 2,
            12, 645, 1288, 13, 1'b0, -1, 0, 0);
    // Reset during write 100, then a normal command
    run_cmd("abort", 9'd10, 8'd10, 10'd50, 9'd30, 8'hE0, 10, 60, 10,
            1500, 3210, 12539, -1, 1'b0, 100, 0, 0);
    run_cmd("after_rst", 9'd10, 8'd10, 10'd50, 9'd30, 8'h3C, 10, 60, 10,
            1500, 3210, 12539, -1, 1'b0, -1, 0, 0);
`ifdef FB_RECT_FILL_GRANT_EN
    // Grant withdrawn for 5 cycles mid-row
    run_cmd("grant_stall", 9'd5, 8'd2, 10'd4, 9'd3, 8'h77, 5, 9, 2,
            12, 645, 1288, -1, 1'b0, -1, 4, 5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
